// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous clock in clk_in cycles,
// with a one-cycle valid pulse per complete period and a sticky stall timeout.
`timescale 1ns/1ps
module clk_period_meter #(
    parameter int unsigned      CNT_W   = 24,
    parameter logic [CNT_W-1:0] TIMEOUT = 24'd2500000
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             meas_clk,
    input  logic             enable,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = TIMEOUT - CNT_ONE;

    logic             s1_r;
    logic             s2_r;
    logic             s3_r;
    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] hcnt_r;
    logic [CNT_W-1:0] period_r;
    logic [CNT_W-1:0] high_time_r;
    logic             period_valid_r;
    logic             timeout_r;

    state_t           state_s;
    logic [CNT_W-1:0] cnt_s;
    logic [CNT_W-1:0] hcnt_s;
    logic [CNT_W-1:0] period_s;
    logic [CNT_W-1:0] high_time_s;
    logic             period_valid_s;
    logic             timeout_s;

    logic             lvl_s;
    logic             rise_s;
    logic             at_last_s;

    // Synchronizer plus history flop; runs regardless of FSM state so enable never fakes an edge.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= meas_clk;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    assign lvl_s     = s2_r;
    assign rise_s    = s2_r & ~s3_r;
    assign at_last_s = (cnt_r == CNT_LAST);

    // Next-state and counter/result update; a rise always beats the timeout check.
    always_comb begin
        state_s        = state_r;
        cnt_s          = cnt_r;
        hcnt_s         = hcnt_r;
        period_s       = period_r;
        high_time_s    = high_time_r;
        period_valid_s = 1'b0;
        timeout_s      = timeout_r;

        if (!enable) begin
            state_s   = IDLE;
            cnt_s     = CNT_ZERO;
            hcnt_s    = CNT_ZERO;
            timeout_s = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = ARM;
                    cnt_s   = CNT_ZERO;
                    hcnt_s  = CNT_ZERO;
                end
                ARM: begin
                    if (rise_s) begin
                        state_s = MEAS;
                        cnt_s   = CNT_ZERO;
                        hcnt_s  = CNT_ONE;
                    end else if (at_last_s) begin
                        state_s   = ARM;
                        timeout_s = 1'b1;
                        cnt_s     = CNT_ZERO;
                        hcnt_s    = CNT_ZERO;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                MEAS: begin
                    if (rise_s) begin
                        period_s       = cnt_r + CNT_ONE;
                        high_time_s    = hcnt_r;
                        period_valid_s = 1'b1;
                        timeout_s      = 1'b0;
                        cnt_s          = CNT_ZERO;
                        hcnt_s         = CNT_ONE;
                    end else if (at_last_s) begin
                        state_s   = ARM;
                        timeout_s = 1'b1;
                        cnt_s     = CNT_ZERO;
                        hcnt_s    = CNT_ZERO;
                    end else begin
                        cnt_s  = cnt_r + CNT_ONE;
                        hcnt_s = hcnt_r + {{(CNT_W-1){1'b0}}, lvl_s};
                    end
                end
                default: begin
                    state_s   = IDLE;
                    cnt_s     = CNT_ZERO;
                    hcnt_s    = CNT_ZERO;
                    timeout_s = 1'b0;
                end
            endcase
        end
    end

    // State, counters and registered results.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_r        <= IDLE;
            cnt_r          <= CNT_ZERO;
            hcnt_r         <= CNT_ZERO;
            period_r       <= CNT_ZERO;
            high_time_r    <= CNT_ZERO;
            period_valid_r <= 1'b0;
            timeout_r      <= 1'b0;
        end else begin
            state_r        <= state_s;
            cnt_r          <= cnt_s;
            hcnt_r         <= hcnt_s;
            period_r       <= period_s;
            high_time_r    <= high_time_s;
            period_valid_r <= period_valid_s;
            timeout_r      <= timeout_s;
        end
    end

    assign period       = period_r;
    assign high_time    = high_time_r;
    assign period_valid = period_valid_r;
    assign timeout      = timeout_r;

endmodule

// File: tb/tb_clk_period_meter.sv
// Bench for clk_period_meter: table vectors, hand-written corner sequences and
// random waveforms checked against a rise-to-rise reference model.
`timescale 1ns/1ps
module tb_clk_period_meter;

    localparam int CW = 24;

    logic          clk_in = 1'b0;
    logic          rst;
    logic          meas_clk;
    logic          enable;
    logic [CW-1:0] period;
    logic [CW-1:0] high_time;
    logic          period_valid;
    logic          timeout;

    clk_period_meter #(.CNT_W(24), .TIMEOUT(24'd64)) dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .meas_clk     (meas_clk),
        .enable       (enable),
        .period       (period),
        .high_time    (high_time),
        .period_valid (period_valid),
        .timeout      (timeout)
    );

    always #20 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [CW-1:0] p;
        logic [CW-1:0] h;
        logic          to;
    } meas_t;

    typedef struct {
        int p;
        int h;
        int n;
        int exp_p;
        int exp_h;
    } vec_t;

    meas_t got_q[$];
    logic  prev_v = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Collect every valid pulse away from the active edge.
    always @(negedge clk_in) begin
        if (rst) begin
            prev_v <= 1'b0;
        end else begin
            if (period_valid) begin
                got_q.push_back('{period, high_time, timeout});
                check("no_back_to_back_valid", {31'd0, prev_v}, 32'd0);
            end
            prev_v <= period_valid;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic drive_period(input int p, input int h);
        meas_clk = 1'b1;
        tick(h);
        meas_clk = 1'b0;
        tick(p - h);
    endtask

    task automatic restart();
        enable   = 1'b0;
        meas_clk = 1'b0;
        tick(3);
        got_q.delete();
        enable = 1'b1;
        tick(4);
    endtask

    // Closing rise: valid registers 3 edges after meas_clk goes high.
    task automatic close_rise();
        meas_clk = 1'b1;
        tick(3);
        check("close_valid_pulse", {31'd0, period_valid}, 32'd1);
        tick(2);
        meas_clk = 1'b0;
        tick(2);
    endtask

    task automatic check_q(input string name, input int n, input int p, input int h);
        check({name, "_count"}, got_q.size(), n);
        foreach (got_q[i]) begin
            check({name, "_period"}, 32'(got_q[i].p), p);
            check({name, "_high"}, 32'(got_q[i].h), h);
            check({name, "_timeout"}, {31'd0, got_q[i].to}, 32'd0);
            check({name, "_high_le_period"}, {31'd0, got_q[i].h <= got_q[i].p}, 32'd1);
        end
        got_q.delete();
    endtask

    initial begin
        vec_t vecs[6];
        bit   wave[$];
        int   rises[$];

        vecs[0] = '{10, 5,  3, 10, 5};
        vecs[1] = '{25, 5,  3, 25, 5};
        vecs[2] = '{2,  1,  4, 2,  1};
        vecs[3] = '{64, 32, 2, 64, 32};
        vecs[4] = '{3,  2,  3, 3,  2};
        vecs[5] = '{40, 39, 2, 40, 39};

        rst      = 1'b1;
        enable   = 1'b0;
        meas_clk = 1'b0;
        tick(3);
        check("reset_period", 32'(period), 32'd0);
        check("reset_high", 32'(high_time), 32'd0);
        check("reset_valid", {31'd0, period_valid}, 32'd0);
        check("reset_timeout", {31'd0, timeout}, 32'd0);
        rst = 1'b0;
        tick(2);

        // Table vectors: first rise discarded, each later rise reports one period.
        for (int v = 0; v < 6; v++) begin
            restart();
            for (int k = 0; k < vecs[v].n; k++) drive_period(vecs[v].p, vecs[v].h);
            close_rise();
            check_q("vec", vecs[v].n, vecs[v].exp_p, vecs[v].exp_h);
        end

        // Timeout 64 edges after the detected rise, then restart needs two rises.
        restart();
        drive_period(10, 5);
        drive_period(10, 5);
        meas_clk = 1'b1;
        for (int n = 1; n <= 66; n++) begin
            tick(1);
            if (n == 5) meas_clk = 1'b0;
        end
        check("s3_timeout_not_early", {31'd0, timeout}, 32'd0);
        tick(1);
        check("s3_timeout_fires", {31'd0, timeout}, 32'd1);
        check("s3_period_held", 32'(period), 32'd10);
        check("s3_high_held", 32'(high_time), 32'd5);
        check_q("s3_pre", 2, 10, 5);
        drive_period(10, 5);
        check("s3_first_rise_timeout_sticky", {31'd0, timeout}, 32'd1);
        check("s3_first_rise_no_valid", got_q.size(), 32'd0);
        meas_clk = 1'b1;
        tick(3);
        check("s3_second_rise_valid", {31'd0, period_valid}, 32'd1);
        check("s3_second_rise_timeout_clear", {31'd0, timeout}, 32'd0);
        tick(2);
        meas_clk = 1'b0;
        tick(2);
        check_q("s3_post", 1, 10, 5);

        // Period of exactly 64 is valid; 65 times out without a pulse.
        restart();
        drive_period(64, 32);
        drive_period(64, 32);
        drive_period(64, 32);
        drive_period(65, 32);
        check("s4_no_early_timeout", {31'd0, timeout}, 32'd0);
        check_q("s4_64", 3, 64, 32);
        meas_clk = 1'b1;
        tick(3);
        check("s4_65_timeout", {31'd0, timeout}, 32'd1);
        check("s4_65_no_valid", {31'd0, period_valid}, 32'd0);
        check("s4_65_period_held", 32'(period), 32'd64);
        tick(2);
        meas_clk = 1'b0;
        tick(2);
        check("s4_65_no_queued_valid", got_q.size(), 32'd0);

        // Enable drop clears timeout, holds results; re-enable while high needs a fresh rise.
        restart();
        drive_period(10, 5);
        drive_period(10, 5);
        meas_clk = 1'b1;
        tick(4);
        meas_clk = 1'b0;
        tick(70);
        check("s5_timeout_before_drop", {31'd0, timeout}, 32'd1);
        enable = 1'b0;
        tick(1);
        check("s5_drop_timeout_clear", {31'd0, timeout}, 32'd0);
        check("s5_drop_no_valid", {31'd0, period_valid}, 32'd0);
        check("s5_drop_period_held", 32'(period), 32'd10);
        check("s5_drop_high_held", 32'(high_time), 32'd5);
        meas_clk = 1'b1;
        tick(4);
        check_q("s5_pre", 2, 10, 5);
        enable = 1'b1;
        tick(6);
        meas_clk = 1'b0;
        tick(10);
        check("s5_level_not_rise", got_q.size(), 32'd0);
        drive_period(20, 10);
        check("s5_one_rise_no_valid", got_q.size(), 32'd0);
        drive_period(20, 10);
        close_rise();
        check_q("s5_post", 2, 20, 10);

        // Asynchronous reset mid-measurement.
        restart();
        drive_period(10, 5);
        drive_period(10, 5);
        meas_clk = 1'b1;
        tick(4);
        #5;
        rst = 1'b1;
        #1;
        check("s6_rst_period", 32'(period), 32'd0);
        check("s6_rst_high", 32'(high_time), 32'd0);
        check("s6_rst_valid", {31'd0, period_valid}, 32'd0);
        check("s6_rst_timeout", {31'd0, timeout}, 32'd0);
        meas_clk = 1'b0;
        tick(3);
        check_q("s6_pre", 2, 10, 5);
        rst = 1'b0;
        tick(4);
        drive_period(10, 5);
        drive_period(10, 5);
        close_rise();
        check_q("s6_post", 2, 10, 5);

        // Random waveforms; model derives each report from successive rises of the drive.
        for (int run = 0; run < 4; run++) begin
            restart();
            wave.delete();
            rises.delete();
            for (int k = 0; k < 12; k++) begin
                int p;
                int h;
                p = int'($urandom_range(64, 2));
                h = int'($urandom_range(p - 1, 1));
                for (int j = 0; j < p; j++) wave.push_back(j < h);
            end
            for (int j = 0; j < 8; j++) wave.push_back(j < 4);
            foreach (wave[i]) begin
                meas_clk = wave[i];
                tick(1);
            end
            meas_clk = 1'b0;
            tick(3);
            foreach (wave[i]) begin
                if (wave[i] && (i == 0 || !wave[i-1])) rises.push_back(i);
            end
            check("rand_count", got_q.size(), rises.size() - 1);
            for (int k = 0; k + 1 < rises.size(); k++) begin
                int ones;
                ones = 0;
                for (int j = rises[k]; j < rises[k+1]; j++) ones += int'(wave[j]);
                if (k < got_q.size()) begin
                    check("rand_period", 32'(got_q[k].p), rises[k+1] - rises[k]);
                    check("rand_high", 32'(got_q[k].h), ones);
                    check("rand_timeout", {31'd0, got_q[k].to}, 32'd0);
                end
            end
            got_q.delete();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
